// File: rtl/uart_rx_os.sv
//============================================================================
// Module   : uart_rx_os
// Purpose  : Oversampling UART receiver. Samples each bit in the middle of
//            its period (OVERSAMPLE clk per bit). Filters glitches on the
//            start bit, checks the stop bit and flags overruns. Completed
//            words are handed to the consumer with a rdy/ack handshake.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters:
//   DATA_BITS  - data bits per frame, LSB first (5..9)
//   OVERSAMPLE - clk cycles per bit period (even, >= 4)
//   PARITY_ODD - 0 = even parity, 1 = odd parity (parity build only)
// Optional feature macro:
//   UART_RX_PARITY_EN - when defined, a parity bit is expected between the
//                       last data bit and the stop bit, and mismatches set
//                       parity_err_o. When undefined, parity_err_o is 0.
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   rx_i         in   serial line, idle high, asynchronous to clk
//   ack_i        in   consumer acknowledge; clears rdy and error flags
//   data_o       out  last good received word
//   rdy_o        out  data_o holds an unacknowledged word
//   frame_err_o  out  sticky: stop bit sampled low
//   overrun_o    out  sticky: good word arrived while rdy_o was set
//   parity_err_o out  sticky: parity mismatch
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    input  logic                 ack_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 rdy_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 parity_err_o
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    // Counter value seen on the edge that lands mid-start-bit / mid-bit.
    localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_LOAD   = 3'd5;
    localparam logic [2:0] ST_BREAK  = 3'd6;

    // ------------------------------------------------------------------
    // Input synchroniser (resets to the idle level)
    // ------------------------------------------------------------------
    logic sync1_q;
    logic rx_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            rx_s_q  <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 rdy_q, rdy_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 parity_err_q, parity_err_d;
    // Set once rx_s has been seen high in IDLE; a frame already in flight
    // when reset is released must not be picked up mid-way.
    logic                 armed_q, armed_d;

    // Strobes produced by the output process
    logic half_tick;
    logic bit_tick;
    logic shift_en;
    logic load_en;
    logic stop_bad;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (armed_q && !rx_s_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // A start bit that is high again mid-period was a glitch.
                if (half_tick) begin
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick && (idx_q == C_IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    state_d = rx_s_q ? ST_LOAD : ST_BREAK;
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            ST_BREAK: begin
                // Hold off until the line returns high so a held-low line
                // cannot look like a new start bit.
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / strobe logic
    // ------------------------------------------------------------------
    always_comb begin
        half_tick = (state_q == ST_START) && (cnt_q == C_CNT_HALF);
        bit_tick  = (cnt_q == C_CNT_LAST);
        shift_en  = (state_q == ST_DATA) && bit_tick;
        load_en   = (state_q == ST_LOAD);
        stop_bad  = (state_q == ST_STOP) && bit_tick && !rx_s_q;
    end

    // ------------------------------------------------------------------
    // Parity tracking
    // ------------------------------------------------------------------
`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;

    always_comb begin
        par_bad_d = par_bad_q;
        if ((state_q == ST_PARITY) && bit_tick) begin
            // Even parity: data ones plus parity bit must be even.
            par_bad_d = ((^shift_q) ^ rx_s_q) != PARITY_ODD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_q <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Datapath next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        armed_d      = armed_q;
        rdy_d        = rdy_q & ~ack_i;
        frame_err_d  = frame_err_q & ~ack_i;
        overrun_d    = overrun_q & ~ack_i;
        parity_err_d = parity_err_q & ~ack_i;

        // Bit-period counter: restarted at t0 and again at mid-start-bit
        // so that every later wrap lands in the middle of a bit.
        case (state_q)
            ST_START: begin
                cnt_d = half_tick ? '0 : cnt_q + CNT_W'(1);
                idx_d = '0;
            end
            ST_DATA,
`ifdef UART_RX_PARITY_EN
            ST_PARITY,
`endif
            ST_STOP: begin
                cnt_d = bit_tick ? '0 : cnt_q + CNT_W'(1);
            end
            default: begin
                cnt_d = '0;
            end
        endcase

        if ((state_q == ST_IDLE) && rx_s_q) begin
            armed_d = 1'b1;
        end

        if (shift_en) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            idx_d   = idx_q + IDX_W'(1);
        end

        // A load wins over a coincident ack: the new word stays pending.
        if (load_en) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
            if (rdy_q && !ack_i) begin
                overrun_d = 1'b1;
            end
        end

        if (stop_bad) begin
            frame_err_d = 1'b1;
        end

`ifdef UART_RX_PARITY_EN
        if ((load_en || stop_bad) && par_bad_q) begin
            parity_err_d = 1'b1;
        end
`else
        parity_err_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            rdy_q        <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            rdy_q        <= rdy_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
            armed_q      <= armed_d;
        end
    end

    assign data_o       = data_q;
    assign rdy_o        = rdy_q;
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;
    assign parity_err_o = parity_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_os.sv
//============================================================================
// Module   : tb_uart_rx_os
// Purpose  : Directed self-checking bench for uart_rx_os (DATA_BITS=8,
//            OVERSAMPLE=16). Frames are driven bit by bit; expected values
//            are hand-derived constants.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_os;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // Cycles from the first low drive of rx to the edge before rdy rises:
    // 2 sync + 1 detect + 8 half-bit + 9 (or 10) bit periods = 155 (171).
    localparam int LOAD_CYC = 155 + (PAR_EN ? OVERSAMPLE : 0);

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       ack   = 1'b0;
    logic [7:0] data;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks  = 0;
    int errors  = 0;
    bit tx_busy = 1'b0;

    always #5 clk = ~clk;

    uart_rx_os #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx),
        .ack_i        (ack),
        .data_o       (data),
        .rdy_o        (rdy),
        .frame_err_o  (frame_err),
        .overrun_o    (overrun),
        .parity_err_o (parity_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called 1 ns after a rising edge; returns 1 ns after a rising edge.
    // The line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit);
        tx_busy = 1'b1;
        rx = 1'b0;
        repeat (OVERSAMPLE) @(posedge clk);
        for (int i = 0; i < DATA_BITS; i++) begin
            #1 rx = d[i];
            repeat (OVERSAMPLE) @(posedge clk);
        end
        if (PAR_EN) begin
            #1 rx = (^d) ^ par_flip;
            repeat (OVERSAMPLE) @(posedge clk);
        end
        #1 rx = stop_bit;
        repeat (OVERSAMPLE) @(posedge clk);
        #1 tx_busy = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic wait_tx();
        while (tx_busy) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        idle(3);
        @(negedge clk);
        chk("rst_data", data, 32'h0);
        chk("rst_rdy", rdy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_perr", parity_err, 0);
        step();
        rst_n = 1'b1;
        idle(4);

        // ---------------- 1: 0xA5 with exact rdy timing ----------------
        fork
            send_frame(8'hA5, 1'b0, 1'b1);
        join_none
        repeat (LOAD_CYC) @(posedge clk);
        @(negedge clk);
        chk("t1_rdy_early", rdy, 0);
        @(posedge clk);
        @(negedge clk);
        chk("t1_rdy", rdy, 1);
        chk("t1_data", data, 32'hA5);
        chk("t1_ferr", frame_err, 0);
        chk("t1_ovr", overrun, 0);
        chk("t1_perr", parity_err, 0);
        wait_tx();
        pulse_ack();
        @(negedge clk);
        chk("t1_ack_rdy", rdy, 0);
        step();

        // ---------------- 2: start glitch then 0x3C ----------------
        rx = 1'b0;
        repeat (6) @(posedge clk);
        #1 rx = 1'b1;
        idle(40);
        @(negedge clk);
        chk("t2_glitch_rdy", rdy, 0);
        chk("t2_glitch_data", data, 32'hA5);
        step();
        send_frame(8'h3C, 1'b0, 1'b1);
        @(negedge clk);
        chk("t2_rdy", rdy, 1);
        chk("t2_data", data, 32'h3C);
        step();
        pulse_ack();

        // ---------------- 3: framing error + break ----------------
        send_frame(8'h11, 1'b0, 1'b0);
        idle(400);
        rx = 1'b1;
        idle(40);
        @(negedge clk);
        chk("t3_ferr", frame_err, 1);
        chk("t3_rdy", rdy, 0);
        chk("t3_data", data, 32'h3C);
        chk("t3_perr", parity_err, 0);
        step();
        send_frame(8'h22, 1'b0, 1'b1);
        @(negedge clk);
        chk("t3_next_rdy", rdy, 1);
        chk("t3_next_data", data, 32'h22);
        chk("t3_ferr_sticky", frame_err, 1);
        step();
        pulse_ack();
        @(negedge clk);
        chk("t3_ack_ferr", frame_err, 0);
        chk("t3_ack_rdy", rdy, 0);
        step();

        // ---------------- 4: overrun, then ack coincident with load ----------------
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'h02, 1'b0, 1'b1);
        @(negedge clk);
        chk("t4_data", data, 32'h02);
        chk("t4_rdy", rdy, 1);
        chk("t4_ovr", overrun, 1);
        step();
        pulse_ack();
        @(negedge clk);
        chk("t4_ack_ovr", overrun, 0);
        chk("t4_ack_rdy", rdy, 0);
        step();
        send_frame(8'h01, 1'b0, 1'b1);
        @(negedge clk);
        chk("t4b_first_rdy", rdy, 1);
        step();
        fork
            send_frame(8'h02, 1'b0, 1'b1);
        join_none
        repeat (LOAD_CYC) @(posedge clk);
        #1 ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        @(negedge clk);
        chk("t4b_rdy", rdy, 1);
        chk("t4b_data", data, 32'h02);
        chk("t4b_ovr", overrun, 0);
        wait_tx();

        // ---------------- 5: reset during data bit 3 ----------------
        fork
            send_frame(8'hFD, 1'b0, 1'b1);
        join_none
        repeat (70) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_data", data, 32'h0);
        chk("t5_async_rdy", rdy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_tx();
        idle(40);
        @(negedge clk);
        chk("t5_ignored_rdy", rdy, 0);
        chk("t5_ignored_data", data, 32'h0);
        step();
        send_frame(8'h7E, 1'b0, 1'b1);
        @(negedge clk);
        chk("t5_rdy", rdy, 1);
        chk("t5_data", data, 32'h7E);
        step();
        pulse_ack();

`ifdef UART_RX_PARITY_EN
        // ---------------- 6: parity ----------------
        send_frame(8'h03, 1'b1, 1'b1);
        @(negedge clk);
        chk("t6_bad_rdy", rdy, 1);
        chk("t6_bad_data", data, 32'h03);
        chk("t6_bad_perr", parity_err, 1);
        step();
        pulse_ack();
        @(negedge clk);
        chk("t6_ack_perr", parity_err, 0);
        step();
        send_frame(8'h03, 1'b0, 1'b1);
        @(negedge clk);
        chk("t6_good_rdy", rdy, 1);
        chk("t6_good_perr", parity_err, 0);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
